drv_sgmnt_scan: RTL and testbench
=================================

DRV_SGMNT_SCAN -- requirements
Module: drv_sgmnt_scan

Interface
REQ-001 SHALL have parameter p_digits, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter p_refresh, default 50_000: clocks per digit slot, at least 2.
REQ-003 SHALL have parameter p_ghost, default 500: anti-ghost dead clocks at the start of each slot, range 0..p_refresh-1.
REQ-004 SHALL have parameter p_blink, default 12_500_000: clocks per blink half-period, at least 1.
REQ-005 SHALL have parameter p_active_low, default 1: 1 means common-anode, active-low pins.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port i_data, input, 4*p_digits bits: hex nibbles; digit k is i_data[4k+3:4k], and digit 0 is the rightmost digit.
REQ-009 SHALL have port i_dp, input, p_digits bits: decimal-point request per digit.
REQ-010 SHALL have port i_blink, input, p_digits bits: blink enable per digit.
REQ-011 SHALL have port i_blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-012 SHALL have port i_load, input, 1 bit: single-cycle strobe that captures i_data and i_dp.
REQ-013 SHALL have port o_sgmnt, output, 7 bits: segments, with bit0 = a through bit6 = g.
REQ-014 SHALL have port o_dp, output, 1 bit: decimal-point segment.
REQ-015 SHALL have port o_dig, output, p_digits bits: digit enables, one-hot or all inactive.
REQ-016 SHALL have port o_frame, output, 1 bit: one-cycle pulse at each frame start.

Function
REQ-017 SHALL keep slot counter cnt (0..p_refresh-1) and digit index idx (0..p_digits-1); cnt increments every clock.
REQ-018 SHALL wrap cnt to 0 and advance idx when cnt==p_refresh-1; idx wraps from p_digits-1 to 0.
REQ-019 SHALL define the frame-start event as cnt==p_refresh-1 with idx==p_digits-1; o_frame is high the cycle after this event.
REQ-020 SHALL hold two registers, pending and active, each carrying data and dp.
REQ-021 SHALL copy i_data and i_dp into pending on i_load, and copy pending into active on frame start.
REQ-022 SHALL, when i_load coincides with frame start, load i_data and i_dp into both active and pending directly.
REQ-023 SHALL leave active unchanged across frames when there is no i_load.
REQ-024 SHALL decode active nibble idx, logical (active-high), as: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 SHALL, when i_blank_lz=1, blank digit k>0 if it and every higher digit are 0; digit 0 is never blanked by this rule.
REQ-026 SHALL toggle a blink phase flag every p_blink clocks; when the phase is 1, every digit with i_blink[k]=1 is blanked.
REQ-027 SHALL, for a blanked digit, drive segments off, dp off and its o_dig bit inactive.
REQ-028 SHALL drive all o_dig bits inactive while cnt < p_ghost; at most one o_dig bit is ever active.
REQ-029 SHALL register o_sgmnt, o_dp, o_dig and o_frame, each with exactly 1 cycle of latency from (cnt, idx, active).
REQ-030 SHALL invert o_sgmnt, o_dp and o_dig when p_active_low=1; o_frame is always active-high.
REQ-031 SHALL sample i_blank_lz and i_blink live, without capture.

Reset
REQ-032 SHALL, while i_rst=0, clear cnt, idx, blink phase, pending and active to 0, and hold o_frame=0.
REQ-033 SHALL, while i_rst=0, drive o_sgmnt, o_dp and o_dig inactive (all ones when p_active_low=1).
REQ-034 SHALL apply reset asynchronously and release it on the first i_clk edge with i_rst=1.
REQ-035 SHALL, on reset mid-frame, discard pending and the current frame, and restart at slot 0 with cnt=0.

Verification (p_digits=4, p_refresh=8, p_ghost=2, p_blink=64, p_active_low=0)
REQ-036 SHALL cover: release reset, no load -> o_dig stays 0 for the first 3 edges, then o_dig=0001 and o_sgmnt=3F for 6 cycles, then 0010 with 3F.
REQ-037 SHALL cover: i_load with i_data=1234 and i_dp=0100 mid-frame -> the display is unchanged until o_frame; the next frame shows 4:66, 3:4F, 2:5B with o_dp=1, 1:06.
REQ-038 SHALL cover: i_data=0050 with i_blank_lz=1 -> digits 3 and 2 are never enabled; digit 1 shows 6D and digit 0 shows 3F.
REQ-039 SHALL cover: i_blink=0001 -> digit 0 is enabled only while the blink phase is 0, for 64-clock windows.
REQ-040 SHALL cover: i_load of ABCD on the frame-start cycle -> the very next slot shows 5E (d).
REQ-041 SHALL cover: i_rst=0 asserted between clock edges mid-slot -> outputs go inactive immediately, and the scan restarts at digit 0 after release.

Source files
------------

// File: rtl/drv_sgmnt_scan.sv
// Multiplexed 7-segment scanner: double-buffered hex data, leading-zero blanking, blink, anti-ghost.
// All outputs are registered, one cycle behind (cnt, idx, active); free-running, with no backpressure.
module drv_sgmnt_scan #(
    parameter int p_digits     = 4,
    parameter int p_refresh    = 50_000,
    parameter int p_ghost      = 500,
    parameter int p_blink      = 12_500_000,
    parameter int p_active_low = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*p_digits-1:0]   i_data,
    input  logic [p_digits-1:0]     i_dp,
    input  logic [p_digits-1:0]     i_blink,
    input  logic                    i_blank_lz,
    input  logic                    i_load,
    output logic [6:0]              o_sgmnt,
    output logic                    o_dp,
    output logic [p_digits-1:0]     o_dig,
    output logic                    o_frame
);

    localparam int CW = $clog2(p_refresh);
    localparam int IW = (p_digits > 1) ? $clog2(p_digits) : 1;
    localparam int BW = (p_blink > 1) ? $clog2(p_blink) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(p_refresh - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(p_digits - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(p_blink - 1);
    localparam logic          INV      = (p_active_low != 0);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [BW-1:0]          bcnt;
    logic                   phase;
    logic [4*p_digits-1:0]  pend_data, act_data;
    logic [p_digits-1:0]    pend_dp, act_dp;

    logic                   slot_end, frame_start;
    logic [p_digits-1:0]    lz_blank, dig_sel, nxt_dig;
    logic [3:0]             nib;
    logic                   dp_sel, blank, ghost, zrun, nxt_dp;
    logic [6:0]             nxt_seg;

    assign slot_end    = (cnt == CNT_LAST);
    assign frame_start = slot_end && (idx == IDX_LAST);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        lz_blank = '0;
        zrun     = 1'b1;
        // Walk from the most significant digit down; a digit is a leading zero while the run holds.
        for (int k = p_digits - 1; k >= 0; k--) begin
            zrun        = zrun & (act_data[4*k +: 4] == 4'h0);
            lz_blank[k] = zrun && (k != 0) && i_blank_lz;
        end

        nib     = '0;
        dp_sel  = 1'b0;
        blank   = 1'b0;
        dig_sel = '0;
        for (int k = 0; k < p_digits; k++) begin
            if (idx == IW'(k)) begin
                nib        = act_data[4*k +: 4];
                dp_sel     = act_dp[k];
                blank      = lz_blank[k] | (phase & i_blink[k]);
                dig_sel[k] = 1'b1;
            end
        end

        ghost   = int'(cnt) < p_ghost;
        nxt_seg = blank ? 7'h00 : hex7(nib);
        nxt_dp  = !blank && dp_sel;
        nxt_dig = (blank || ghost) ? '0 : dig_sel;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt       <= '0;
            idx       <= '0;
            bcnt      <= '0;
            phase     <= 1'b0;
            pend_data <= '0;
            pend_dp   <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            o_sgmnt   <= {7{INV}};
            o_dp      <= INV;
            o_dig     <= {p_digits{INV}};
            o_frame   <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            if (bcnt == BLK_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + 1'b1;
            end

            if (i_load) begin
                pend_data <= i_data;
                pend_dp   <= i_dp;
            end
            // A load landing on the frame boundary bypasses pending so it shows immediately.
            if (frame_start) begin
                act_data <= i_load ? i_data : pend_data;
                act_dp   <= i_load ? i_dp   : pend_dp;
            end

            o_sgmnt <= nxt_seg ^ {7{INV}};
            o_dp    <= nxt_dp ^ INV;
            o_dig   <= nxt_dig ^ {p_digits{INV}};
            o_frame <= frame_start;
        end
    end

endmodule

// File: tb/tb_drv_sgmnt_scan.sv
// Scoreboarded bench for drv_sgmnt_scan with a small, fast-scanning configuration.
module tb_drv_sgmnt_scan;

    localparam int D = 4;
    localparam int R = 8;
    localparam int G = 2;
    localparam int B = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  sgmnt;
    logic        odp;
    logic [3:0]  dig;
    logic        frame;

    always #5 clk = ~clk;

    drv_sgmnt_scan #(
        .p_digits(D), .p_refresh(R), .p_ghost(G), .p_blink(B), .p_active_low(0)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_dp(dp), .i_blink(blink),
        .i_blank_lz(blank_lz), .i_load(load),
        .o_sgmnt(sgmnt), .o_dp(odp), .o_dig(dig), .o_frame(frame)
    );

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  c = 0;

    // Cycle number since reset release; cycle n is the interval after the n-th rising edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) c = 0;
            else        c = c + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, c);
        end
    endtask

    // Digit d of frame f first shows at frame start + 8*d + ghost (2) + register stage (1).
    task automatic exp_slot(input int f, input int d, input logic [6:0] seg, input logic p);
        ev_t e;
        e.cyc = 32*f + 8*d + 3;
        e.dig = 4'(1 << d);
        e.seg = seg;
        e.dp  = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycle(input int n);
        while (c < n) @(negedge clk);
    endtask

    // Monitor: one scoreboard entry per enabled digit window, plus frame-pulse and window-length checks.
    initial begin
        logic [3:0] prev_dig;
        int         run_len;
        bit         run_ok;
        ev_t        e;
        prev_dig = '0;
        run_len  = 0;
        run_ok   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_dig = '0;
                run_len  = 0;
                run_ok   = 0;
            end else begin
                check("dig_onehot0", int'($onehot0(dig)), 1);
                if ((c > 0 && c % 32 == 0) || frame)
                    check("frame_pulse", int'(frame), int'(c > 0 && c % 32 == 0));
                if (dig != prev_dig) begin
                    if (prev_dig != 0 && run_ok)
                        check("window_len", run_len, R - G);
                    run_ok  = 0;
                    run_len = 0;
                    if (dig != 0) begin
                        run_ok  = 1;
                        run_len = 1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_slot: got dig %b seg %h at cycle %0d, expected none", dig, sgmnt, c);
                        end else begin
                            e = exp_q.pop_front();
                            check("slot_cycle", c, e.cyc);
                            check("slot_dig", int'(dig), int'(e.dig));
                            check("slot_seg", int'(sgmnt), int'(e.seg));
                            check("slot_dp", int'(odp), int'(e.dp));
                        end
                    end
                end else if (dig != 0) begin
                    run_len++;
                end
                prev_dig = dig;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", c);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dig", int'(dig), 0);
        check("rst_seg", int'(sgmnt), 0);
        check("rst_dp", int'(odp), 0);
        check("rst_frame", int'(frame), 0);

        // Frames 0-1: blank data, then 1234 loaded mid-frame 1 shows from frame 2.
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 4; d++) exp_slot(f, d, 7'h3F, 1'b0);
        exp_slot(2, 0, 7'h66, 1'b0);
        exp_slot(2, 1, 7'h4F, 1'b0);
        exp_slot(2, 2, 7'h5B, 1'b1);
        exp_slot(2, 3, 7'h06, 1'b0);
        // Frames 3-8: 0050 with leading-zero blanking; digit 0 blinks from frame 4 (phase 1 in frames 6-7).
        exp_slot(3, 0, 7'h3F, 1'b0);
        exp_slot(3, 1, 7'h6D, 1'b0);
        for (int f = 4; f < 9; f++) begin
            if (f != 6 && f != 7) exp_slot(f, 0, 7'h3F, 1'b0);
            exp_slot(f, 1, 7'h6D, 1'b0);
        end
        // Frames 9-10: ABCD loaded on the frame-start cycle; frame 11 cut short by reset.
        for (int f = 9; f < 11; f++) begin
            exp_slot(f, 0, 7'h5E, 1'b0);
            exp_slot(f, 1, 7'h39, 1'b0);
            exp_slot(f, 2, 7'h7C, 1'b0);
            exp_slot(f, 3, 7'h77, 1'b0);
        end
        exp_slot(11, 0, 7'h5E, 1'b0);
        exp_slot(11, 1, 7'h39, 1'b0);

        rst_n = 1'b1;

        wait_cycle(40);
        data = 16'h1234; dp = 4'b0100; load = 1'b1;
        wait_cycle(41);
        load = 1'b0;

        wait_cycle(80);
        data = 16'h0050; dp = 4'b0000; load = 1'b1;
        wait_cycle(81);
        load = 1'b0;

        wait_cycle(90);
        blank_lz = 1'b1;

        wait_cycle(128);
        blink = 4'b0001;

        wait_cycle(287);
        data = 16'hABCD; dp = 4'b0000; load = 1'b1;
        wait_cycle(288);
        load = 1'b0; blink = 4'b0000; blank_lz = 1'b0;

        wait_cycle(360);
        data = 16'h1111; load = 1'b1;
        wait_cycle(361);
        load = 1'b0;

        wait_cycle(364);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dig", int'(dig), 0);
        check("async_rst_seg", int'(sgmnt), 0);
        check("async_rst_dp", int'(odp), 0);
        check("async_rst_frame", int'(frame), 0);

        // Pending 1111 is discarded by reset, so the restarted scan shows zeros from digit 0.
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 4; d++) exp_slot(f, d, 7'h3F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_cycle(66);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
